// File: rtl/data_memory_sized.sv
// Byte-addressed big-endian data memory: valid/ready requests, wait states, serial byte loader.
// state | meaning: S_IDLE accept or load | S_WAIT wait-state countdown | S_RESP response cycle
module data_memory_sized #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic                 resp_valid,
  output logic [31:0]          read_data,
  output logic                 fault,
  input  logic                 load,
  input  logic [7:0]           store,
  output logic [ADDR_BITS-1:0] load_ptr
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        unsigned_q;

  logic [7:0] mem [DEPTH];

  logic                 accept;
  logic                 commit;
  logic                 bypass;
  logic [31:0]          op_addr;
  logic [31:0]          op_wdata;
  logic [1:0]           op_size;
  logic                 op_write;
  logic                 op_unsigned;
  logic                 op_fault;
  logic                 misaligned;
  logic [ADDR_BITS-1:0] idx0;
  logic [ADDR_BITS-1:0] idx1;
  logic [ADDR_BITS-1:0] idx2;
  logic [ADDR_BITS-1:0] idx3;
  logic [7:0]           b0;
  logic [7:0]           b1;
  logic [7:0]           b2;
  logic [7:0]           b3;
  logic [31:0]          rd_ext;

  assign req_ready = (state == S_IDLE) && !load;
  assign accept    = req_valid && req_ready;

  always_comb begin
    commit = 1'b0;
    if (state == S_IDLE) begin
      commit = accept && NO_WAIT;
    end else if (state == S_WAIT) begin
      commit = (wait_cnt == 4'd0);
    end
  end

  // With no wait states the commit edge is the accept edge, so use the live request.
  assign bypass      = (state == S_IDLE);
  assign op_addr     = bypass ? address      : addr_q;
  assign op_wdata    = bypass ? write_data   : wdata_q;
  assign op_size     = bypass ? req_size     : size_q;
  assign op_write    = bypass ? req_write    : write_q;
  assign op_unsigned = bypass ? req_unsigned : unsigned_q;

  assign idx0 = op_addr[ADDR_BITS-1:0];
  assign idx1 = idx0 + ADDR_BITS'(1);
  assign idx2 = idx0 + ADDR_BITS'(2);
  assign idx3 = idx0 + ADDR_BITS'(3);

  always_comb begin
    misaligned = 1'b0;
    case (op_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = op_addr[0];
      2'b10:   misaligned = |op_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    op_fault = misaligned || ((op_addr >> ADDR_BITS) != 32'd0);
  end

  always_comb begin
    b0     = mem[idx0];
    b1     = mem[idx1];
    b2     = mem[idx2];
    b3     = mem[idx3];
    rd_ext = 32'd0;
    case (op_size)
      2'b00:   rd_ext = op_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'b01:   rd_ext = op_unsigned ? {16'd0, b0, b1} : {{16{b0[7]}}, b0, b1};
      2'b10:   rd_ext = {b0, b1, b2, b3};
      default: rd_ext = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= 4'd0;
      resp_valid <= 1'b0;
      read_data  <= 32'd0;
      fault      <= 1'b0;
      load_ptr   <= '0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      size_q     <= 2'b00;
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
    end else begin
      resp_valid <= commit;
      fault      <= commit && op_fault;
      read_data  <= (commit && !op_fault && !op_write) ? rd_ext : 32'd0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q     <= address;
            wdata_q    <= write_data;
            size_q     <= req_size;
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            wait_cnt   <= WAIT_LOAD;
            state      <= NO_WAIT ? S_RESP : S_WAIT;
          end else if (load) begin
            load_ptr <= load_ptr + ADDR_BITS'(1);
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Loader and request commits never coincide: a commit from IDLE requires load=0.
  always_ff @(posedge clk) begin
    if ((state == S_IDLE) && load) begin
      mem[load_ptr] <= store;
    end else if (commit && op_write && !op_fault) begin
      case (op_size)
        2'b00: mem[idx0] <= op_wdata[7:0];
        2'b01: begin
          mem[idx0] <= op_wdata[15:8];
          mem[idx1] <= op_wdata[7:0];
        end
        2'b10: begin
          mem[idx0] <= op_wdata[31:24];
          mem[idx1] <= op_wdata[23:16];
          mem[idx2] <= op_wdata[15:8];
          mem[idx3] <= op_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: zero-wait and three-wait-state instances, scoreboard queue.
module tb_data_memory_sized;

  logic        clk;
  logic        reset;
  logic        v0, v3, load0, load3;
  logic        wr, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wd;
  logic [7:0]  store;
  logic        rdy0, rv0, f0, rdy3, rv3, f3;
  logic [31:0] rd0, rd3;
  logic [9:0]  lp0, lp3;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];

  data_memory_sized #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(rdy0), .req_write(wr),
    .req_size(sz), .req_unsigned(uns), .address(addr), .write_data(wd),
    .resp_valid(rv0), .read_data(rd0), .fault(f0), .load(load0), .store(store),
    .load_ptr(lp0));

  data_memory_sized #(.ADDR_BITS(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_write(wr),
    .req_size(sz), .req_unsigned(uns), .address(addr), .write_data(wd),
    .resp_valid(rv3), .read_data(rd3), .fault(f3), .load(load3), .store(store),
    .load_ptr(lp3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit w, input logic [1:0] s, input bit u,
                       input logic [31:0] a, input logic [31:0] d);
    wr = w; sz = s; uns = u; addr = a; wd = d;
    if (sel) v3 = 1'b1;
    else     v0 = 1'b1;
  endtask

  task automatic expect_resp(input logic [31:0] d, input bit f);
    exp_q.push_back({f, d});
  endtask

  task automatic wait_accept(input bit sel, input bit keep);
    int n = 0;
    bit r = 1'b0;
    while (!r && n < 64) begin
      #1 r = sel ? rdy3 : rdy0;
      @(posedge clk);
      n++;
    end
    chk("accept", 32'(r), 32'd1);
    #1;
    if (!keep) begin
      v0 = 1'b0;
      v3 = 1'b0;
    end
  endtask

  task automatic wait_resp(input bit sel, input int lat_exp);
    int lat = 0;
    bit seen = 1'b0;
    logic [32:0] e;
    while (!seen && lat < 64) begin
      @(negedge clk);
      seen = sel ? rv3 : rv0;
      if (!seen) lat++;
    end
    chk("latency", 32'(lat), 32'(lat_exp));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    chk("rdata", sel ? rd3 : rd0, e[31:0]);
    chk("fault", 32'(sel ? f3 : f0), 32'(e[32]));
    @(negedge clk);
    chk("pulse", 32'(sel ? rv3 : rv0), 32'd0);
  endtask

  task automatic req(input bit sel, input bit w, input logic [1:0] s, input bit u,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] ed, input bit ef);
    @(negedge clk);
    drive(sel, w, s, u, a, d);
    expect_resp(ed, ef);
    wait_accept(sel, 1'b0);
    wait_resp(sel, sel ? 3 : 0);
  endtask

  initial begin
    logic [7:0]  bytes [4];
    logic [32:0] e;
    int k, rv_at, rv_cnt;
    bit r;
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    reset = 1'b1; v0 = 0; v3 = 0; load0 = 0; load3 = 0;
    wr = 0; uns = 0; sz = 2'b00; addr = 0; wd = 0; store = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(rv0), 32'd0);
    chk("rst_read_data", rd0, 32'd0);
    chk("rst_fault", 32'(f0), 32'd0);
    chk("rst_load_ptr", 32'(lp0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready0", 32'(rdy0), 32'd1);
    chk("rst_ready3", 32'(rdy3), 32'd1);

    // word store / load and byte views
    req(0, 1, 2'b10, 0, 32'h10, 32'h11223344, 32'h0, 0);
    req(0, 0, 2'b10, 0, 32'h10, 32'h0, 32'h11223344, 0);
    req(0, 0, 2'b00, 1, 32'h10, 32'h0, 32'h00000011, 0);
    req(0, 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000044, 0);

    // sub-word stores, sign/zero extension, neighbours untouched
    req(0, 1, 2'b10, 0, 32'h20, 32'h0, 32'h0, 0);
    req(0, 1, 2'b00, 0, 32'h21, 32'h12345680, 32'h0, 0);
    req(0, 0, 2'b00, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    req(0, 0, 2'b00, 1, 32'h21, 32'h0, 32'h00000080, 0);
    req(0, 1, 2'b01, 0, 32'h22, 32'h5555BEEF, 32'h0, 0);
    req(0, 0, 2'b01, 0, 32'h22, 32'h0, 32'hFFFFBEEF, 0);
    req(0, 0, 2'b01, 1, 32'h22, 32'h0, 32'h0000BEEF, 0);
    req(0, 0, 2'b10, 0, 32'h20, 32'h0, 32'h0080BEEF, 0);
    req(0, 0, 2'b01, 0, 32'h20, 32'h0, 32'h00000080, 0);

    // faults leave memory alone
    req(0, 1, 2'b10, 0, 32'h0, 32'hCAFEF00D, 32'h0, 0);
    req(0, 0, 2'b10, 0, 32'h2, 32'h0, 32'h0, 1);
    req(0, 0, 2'b01, 0, 32'h3, 32'h0, 32'h0, 1);
    req(0, 1, 2'b11, 0, 32'h0, 32'hFFFFFFFF, 32'h0, 1);
    req(0, 1, 2'b10, 0, 32'h400, 32'h0, 32'h0, 1);
    req(0, 1, 2'b01, 0, 32'h1, 32'h0000FFFF, 32'h0, 1);
    req(0, 0, 2'b11, 0, 32'h0, 32'h0, 32'h0, 1);
    req(0, 0, 2'b00, 0, 32'h400, 32'h0, 32'h0, 1);
    req(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0);
    req(0, 1, 2'b00, 0, 32'h3FF, 32'h0000007F, 32'h0, 0);
    req(0, 0, 2'b00, 0, 32'h3FF, 32'h0, 32'h0000007F, 0);

    // serial loader
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load0 = 1'b1;
      store = bytes[i];
      #1 chk("load_ready", 32'(rdy0), 32'd0);
    end
    @(negedge clk);
    load0 = 1'b0;
    #1 chk("load_ptr4", 32'(lp0), 32'd4);
    req(0, 0, 2'b10, 0, 32'h0, 32'h0, 32'hDEADBEEF, 0);

    // load wins over a simultaneous request
    @(negedge clk);
    drive(0, 0, 2'b10, 0, 32'h4, 32'h0);
    expect_resp(32'h01020304, 0);
    for (int i = 0; i < 4; i++) begin
      load0 = 1'b1;
      store = 8'(i + 1);
      #1;
      chk("collide_ready", 32'(rdy0), 32'd0);
      chk("collide_noresp", 32'(rv0), 32'd0);
      @(negedge clk);
    end
    load0 = 1'b0;
    wait_accept(0, 0);
    wait_resp(0, 0);
    chk("load_ptr8", 32'(lp0), 32'd8);

    // three wait states
    req(1, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0);
    req(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);

    // held request: response at N+4, next accept at N+5
    @(negedge clk);
    drive(1, 0, 2'b10, 0, 32'h40, 32'h0);
    expect_resp(32'hA5A5A5A5, 0);
    expect_resp(32'hA5A5A5A5, 0);
    wait_accept(1, 1);
    k = 0; r = 1'b0; rv_at = 0; rv_cnt = 0;
    while (!r && k < 20) begin
      k++;
      @(negedge clk);
      #1;
      r = rdy3;
      if (rv3) begin
        rv_at = k;
        rv_cnt++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        chk("held_rdata", rd3, e[31:0]);
      end
      @(posedge clk);
    end
    chk("held_accept_gap", 32'(k), 32'd5);
    chk("held_resp_at", 32'(rv_at), 32'd4);
    chk("held_resp_count", 32'(rv_cnt), 32'd1);
    #1 v3 = 1'b0;
    wait_resp(1, 3);

    // reset during WAIT drops the store
    @(negedge clk);
    drive(1, 1, 2'b10, 0, 32'h40, 32'h0BADF00D);
    wait_accept(1, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_load_ptr", 32'(lp0), 32'd0);
    chk("rst_mid_ready", 32'(rdy3), 32'd1);
    rv_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rv3) rv_cnt++;
    end
    chk("rst_mid_noresp", 32'(rv_cnt), 32'd0);
    req(1, 0, 2'b10, 0, 32'h40, 32'h0, 32'hA5A5A5A5, 0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_sized.md
Name: data_memory_sized

Overview:
- Byte-addressed, big-endian data memory for the MIPS datapath.
- Successor of the single-cycle word memory. Adds:
  - parametrised depth and access latency
  - byte, halfword and word accesses with sign or zero extension
  - alignment and range fault detection
  - a valid/ready request handshake
- Keeps the serial byte loader used to preload data before execution.
- Sits between the MEM stage / stall logic and the program loader.

Parameters:
- ADDR_BITS, 10: memory depth is 2^ADDR_BITS bytes.
- WAIT_STATES, 0: extra cycles between request acceptance and response. Legal range 0..15.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- req_unsigned  input  1  zero-extend byte/half reads (lbu/lhu)
- address  input  32  byte address
- write_data  input  32  store data; byte/half taken from the LSBs
- resp_valid  output  1  one-cycle response pulse
- read_data  output  32  extended read result; valid only while resp_valid
- fault  output  1  misaligned, out-of-range or reserved-size access; valid only while resp_valid
- load  input  1  loader strobe
- store  input  8  loader byte
- load_ptr  output  ADDR_BITS  next loader write address

Behaviour:
- Reset (async): FSM -> IDLE; resp_valid=0, read_data=0, fault=0, load_ptr=0, wait counter=0. Memory contents are not reset.
- req_ready = (state==IDLE) && !load.
- A request is accepted on a clock edge with req_valid && req_ready. On acceptance the block captures:
  - address, size, write flag, unsigned flag
  - write_data
- FSM transitions:
  - IDLE -> WAIT on accept when WAIT_STATES>0 (counter loaded with WAIT_STATES-1); IDLE -> RESP on accept when WAIT_STATES=0.
  - WAIT decrements the counter; WAIT -> RESP when counter==0.
  - RESP -> IDLE unconditionally.
- Latency: resp_valid is high for exactly one cycle, WAIT_STATES+1 cycles after the accepting edge. Back-to-back throughput is one request per WAIT_STATES+2 cycles.
- Commit: memory read and write happen on the edge entering RESP. read_data and fault are registered at that edge.
- Byte ordering is big-endian. Word at address A: bits[31:24]=mem[A], [23:16]=mem[A+1], [15:8]=mem[A+2], [7:0]=mem[A+3]. Halfword at A: [15:8]=mem[A], [7:0]=mem[A+1].
- Stores:
  - byte store writes write_data[7:0]
  - half store writes write_data[15:0]
  - word store writes all 32 bits
  - only the addressed bytes change
- Loads:
  - byte/half results are sign-extended unless req_unsigned=1, in which case they are zero-extended
  - word results are passed through unchanged
  - stores return read_data=0
- fault=1 when any of the following holds:
  - size=11
  - half with address[0]=1
  - word with address[1:0]!=0
  - address[31:ADDR_BITS]!=0
- On fault: no memory write, read_data=0, response timing unchanged.
- Loader:
  - In IDLE with load=1, each edge writes store to mem[load_ptr] and increments load_ptr.
  - load_ptr wraps from 2^ADDR_BITS-1 to 0.
  - load outside IDLE is ignored; load_ptr holds.
  - load and req_valid in the same IDLE cycle: load wins and the request is not accepted.
- Reset mid-operation: a pending request is dropped with no write and no response; load_ptr returns to 0.

Test Plan:
- WAIT_STATES=0, sw 0x11223344 @0x10 then lw @0x10 -> resp_valid one cycle after each accept; read_data=0x11223344, fault=0. Byte view: lbu @0x10=0x00000011, lbu @0x13=0x00000044.
- sb 0x80 @0x21, then lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080; sh 0xBEEF @0x22 then lh @0x22 -> 0xFFFFBEEF, lhu -> 0x0000BEEF; neighbour bytes unchanged.
- lw @0x02, lh @0x03, size=11 @0x00, sw @0x400 with ADDR_BITS=10 -> fault=1 and read_data=0 each time; a follow-up lw @0x00 shows memory unchanged.
- WAIT_STATES=3: accept at edge N -> resp_valid at N+4 only; req_ready=0 during N+1..N+4; a request held valid throughout is accepted at N+5.
- Loader: pulse load 4 cycles with 0xDE,0xAD,0xBE,0xEF -> load_ptr=4; lw @0 returns 0xDEADBEEF. Load asserted in the same cycle as req_valid -> request accepted only after load drops.
- Assert reset during WAIT of a sw -> no resp_valid, target word keeps its old value, load_ptr=0, req_ready=1 after reset releases.
